// File: rtl/run_pattern_gen.sv
// Serial run-length pattern generator: turns (bit, length) commands into a one-bit
// stream with a golden "3 or more equal bits in a row" flag for detector benches.
module run_pattern_gen #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             out_valid,
  output logic             out,
  output logic             exp_y,
  output logic             run_done,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t state, state_d;

  // Single-entry command slot between the handshake and the emitter.
  logic             pend_v, pend_v_d;
  logic             pend_bit;
  logic [LEN_W-1:0] pend_len;

  // Active run: bit value and bits still owed after the one currently on out.
  logic             run_bit, run_bit_d;
  logic [LEN_W-1:0] rem, rem_d;

  // Equal-bit tracker; count saturates at 3, 0 means nothing seen since reset.
  logic             last_bit, last_bit_d;
  logic [1:0]       trk_cnt, trk_cnt_d;

  logic accept, consume, load;
  logic out_valid_d, out_d, run_done_d, exp_y_d, busy_d;

  assign accept = cmd_valid & cmd_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic: the slot is consumed either from IDLE or at a run boundary.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    consume = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_v) begin
          consume = 1'b1;
          if (pend_len != '0) begin
            load    = 1'b1;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (rem == '0) begin
          state_d = IDLE;
          if (pend_v) begin
            consume = 1'b1;
            if (pend_len != '0) begin
              load    = 1'b1;
              state_d = EMIT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered stream outputs.
  always_comb begin
    out_valid_d = 1'b0;
    out_d       = 1'b0;
    run_done_d  = 1'b0;
    run_bit_d   = run_bit;
    rem_d       = rem;
    if (load) begin
      out_valid_d = 1'b1;
      out_d       = pend_bit;
      run_bit_d   = pend_bit;
      rem_d       = pend_len - LEN_W'(1);
      run_done_d  = (pend_len == LEN_W'(1));
    end else if (state == EMIT && rem != '0) begin
      out_valid_d = 1'b1;
      out_d       = run_bit;
      rem_d       = rem - LEN_W'(1);
      run_done_d  = (rem == LEN_W'(1));
    end
  end

  // Tracker sees only emitted bits, so runs span idle gaps and command boundaries.
  always_comb begin
    last_bit_d = last_bit;
    trk_cnt_d  = trk_cnt;
    if (out_valid_d) begin
      last_bit_d = out_d;
      if (trk_cnt != 2'd0 && out_d == last_bit)
        trk_cnt_d = (trk_cnt == 2'd3) ? 2'd3 : trk_cnt + 2'd1;
      else
        trk_cnt_d = 2'd1;
    end
    exp_y_d = out_valid_d & (trk_cnt_d == 2'd3);
  end

  // Accept and consume never coincide: accept needs the slot empty, consume needs it full.
  always_comb begin
    pend_v_d = pend_v;
    if (consume)     pend_v_d = 1'b0;
    else if (accept) pend_v_d = 1'b1;
    busy_d = pend_v_d | (state_d == EMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v    <= 1'b0;
      pend_bit  <= 1'b0;
      pend_len  <= '0;
      cmd_ready <= 1'b1;
      run_bit   <= 1'b0;
      rem       <= '0;
      last_bit  <= 1'b0;
      trk_cnt   <= 2'd0;
      out_valid <= 1'b0;
      out       <= 1'b0;
      exp_y     <= 1'b0;
      run_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      pend_v    <= pend_v_d;
      cmd_ready <= ~pend_v_d;
      if (accept) begin
        pend_bit <= cmd_bit;
        pend_len <= cmd_len;
      end
      run_bit   <= run_bit_d;
      rem       <= rem_d;
      last_bit  <= last_bit_d;
      trk_cnt   <= trk_cnt_d;
      out_valid <= out_valid_d;
      out       <= out_d;
      exp_y     <= exp_y_d;
      run_done  <= run_done_d;
      busy      <= busy_d;
    end
  end

endmodule
